// File: rtl/alu_req_scheduler.sv
// -----------------------------------------------------------------------------
// alu_req_scheduler
//   Two-requester round-robin scheduler in front of a single ALU instance.
//   One operation is in flight at a time: a command is accepted over
//   valid/ready, issued to the ALU with a one-cycle start pulse, and the ALU
//   result is returned through a single-entry response register.
//
//   Optional feature macro: ALU_SCHED_TIMEOUT_EN
//     defined   -> WAIT is bounded by TIMEOUT_CYCLES; expiry returns result 0
//                  with rsp_error set.
//     undefined -> WAIT lasts until the ALU reports valid or error.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req_valid[1:0]    per-requester command valid
//   req_ready[1:0]    per-requester accept (at most one bit high, IDLE only)
//   req_ctrl[15:0]    per requester {fp, rs2_signed, rs1_signed, op[4:0]}
//   req_a, req_b      per-requester operands, requester i at [WIDTH*i +: WIDTH]
//   rsp_valid/ready   response handshake
//   rsp_id            requester index of the response
//   rsp_result        captured ALU result (0 on error-only or timeout)
//   rsp_error         ALU error or timeout
//   alu_*  (out)      start pulse, op, fp, operand signedness, operands
//   alu_busy/valid/error/result (in)  ALU status and result
// -----------------------------------------------------------------------------
module alu_req_scheduler #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [15:0]        req_ctrl,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [WIDTH-1:0]   rsp_result,
    output logic               rsp_error,
    output logic               alu_start,
    output logic [4:0]         alu_op,
    output logic               alu_fp,
    output logic               alu_rs1_signed,
    output logic               alu_rs2_signed,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic               alu_busy,
    input  logic               alu_valid,
    input  logic               alu_error,
    input  logic [WIDTH-1:0]   alu_result
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state;
    logic             rr_ptr;     // requester with priority when both are valid
    logic             cur_id;     // requester of the operation in flight
    logic             grant;
    logic             accept;
    logic [7:0]       sel_ctrl;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             timeout_hit;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 12) ? $clog2(TIMEOUT_CYCLES + 1) : 12;
    logic [CNT_W-1:0] wait_cnt;

    // Asserted during the TIMEOUT_CYCLES-th cycle spent in WAIT.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Timeout compiled out; the parameter stays so both builds share one interface.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
    assign timeout_hit    = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        grant     = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        req_ready = 2'b00;
        if (state == S_IDLE && !rst) begin
            req_ready[grant] = req_valid[grant];
        end
        sel_ctrl = grant ? req_ctrl[15:8]       : req_ctrl[7:0];
        sel_a    = grant ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
        sel_b    = grant ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
    end

    assign accept = |(req_valid & req_ready);

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            rr_ptr         <= 1'b0;
            cur_id         <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_result     <= '0;
            rsp_error      <= 1'b0;
            alu_start      <= 1'b0;
            alu_op         <= '0;
            alu_fp         <= 1'b0;
            alu_rs1_signed <= 1'b0;
            alu_rs2_signed <= 1'b0;
            alu_a          <= '0;
            alu_b          <= '0;
`ifdef ALU_SCHED_TIMEOUT_EN
            wait_cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_op         <= sel_ctrl[4:0];
                        alu_rs1_signed <= sel_ctrl[5];
                        alu_rs2_signed <= sel_ctrl[6];
                        alu_fp         <= sel_ctrl[7];
                        alu_a          <= sel_a;
                        alu_b          <= sel_b;
                        cur_id         <= grant;
                        // A busy ALU holds off the start pulse until it frees up.
                        alu_start      <= ~alu_busy;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (alu_start) begin
                        alu_start <= 1'b0;
                        state     <= S_WAIT;
`ifdef ALU_SCHED_TIMEOUT_EN
                        wait_cnt  <= '0;
`endif
                    end else if (!alu_busy) begin
                        alu_start <= 1'b1;
                    end
                end
                S_WAIT: begin
`ifdef ALU_SCHED_TIMEOUT_EN
                    wait_cnt <= wait_cnt + 1'b1;
`endif
                    if (alu_valid) begin
                        rsp_result <= alu_result;
                        rsp_error  <= alu_error;
                        rsp_id     <= cur_id;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end else if (alu_error || timeout_hit) begin
                        // Error without a result, or no answer at all.
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                        rsp_id     <= cur_id;
                        rsp_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= ~rsp_id;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_req_scheduler
//   Self-checking bench for alu_req_scheduler. A behavioural ALU answers each
//   start pulse after a random latency; a reference model predicts grants from
//   the round-robin rule and the response each accepted command must produce.
//   Works with and without ALU_SCHED_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_alu_req_scheduler;

    localparam int W   = 32;
    localparam int TMO = 64;

    typedef struct packed {
        logic         id;
        logic [W-1:0] result;
        logic         err;
    } rsp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [15:0]    req_ctrl;
    logic [2*W-1:0] req_a, req_b;
    logic           rsp_valid, rsp_ready, rsp_id, rsp_error;
    logic [W-1:0]   rsp_result;
    logic           alu_start, alu_fp, alu_rs1_signed, alu_rs2_signed;
    logic [4:0]     alu_op;
    logic [W-1:0]   alu_a, alu_b, alu_result;
    logic           alu_busy, alu_valid, alu_error;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Reference model state
    rsp_t         exp_q[$];
    logic         model_busy = 1'b0;
    logic         pri        = 1'b0;
    logic [1:0]   m_exp_ready;
    logic         m_id;
    logic [7:0]   fl_ctrl;
    logic [W-1:0] fl_a, fl_b;
    int           acc_cyc     = 0;
    int           exp_rsp_cyc = -1;
    logic         rsp_prev    = 1'b0;
    logic         busy_test   = 1'b0;
    logic         rsp_rand    = 1'b0;
    logic [W-1:0] last_res, prev_res;
    logic         last_id, last_err;

    // ALU model scratch
    int           a_lat;
    logic [4:0]   a_op;
    logic [W-1:0] a_a, a_b;

    alu_req_scheduler #(.WIDTH(W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .alu_start(alu_start), .alu_op(alu_op), .alu_fp(alu_fp),
        .alu_rs1_signed(alu_rs1_signed), .alu_rs2_signed(alu_rs2_signed),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_busy(alu_busy), .alu_valid(alu_valid), .alu_error(alu_error),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response expected for a command, from the ALU behaviour used here:
    // op 6 adds, op 7 subtracts, op 10 returns a^b flagged as error,
    // op 11 raises error without valid, op 31 never answers, others xor.
    function automatic rsp_t ref_rsp(input logic id, input logic [4:0] op,
                                     input logic [W-1:0] a, input logic [W-1:0] b);
        rsp_t r;
        r.id  = id;
        r.err = 1'b0;
        case (op)
            5'd6:         r.result = a + b;
            5'd7:         r.result = a - b;
            5'd10:        begin r.result = a ^ b; r.err = 1'b1; end
            5'd11, 5'd31: begin r.result = '0;    r.err = 1'b1; end
            default:      r.result = a ^ b;
        endcase
        return r;
    endfunction

    // Grant/accept prediction and response scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            rsp_prev = 1'b0;
        end else begin
            m_exp_ready = 2'b00;
            if (!model_busy) begin
                case (req_valid)
                    2'b01:   m_exp_ready = 2'b01;
                    2'b10:   m_exp_ready = 2'b10;
                    2'b11:   m_exp_ready = pri ? 2'b10 : 2'b01;
                    default: m_exp_ready = 2'b00;
                endcase
            end
            check("req_ready", req_ready, m_exp_ready);
            if (m_exp_ready != 2'b00) begin
                m_id    = m_exp_ready[1];
                fl_ctrl = m_id ? req_ctrl[15:8] : req_ctrl[7:0];
                fl_a    = m_id ? req_a[W +: W] : req_a[0 +: W];
                fl_b    = m_id ? req_b[W +: W] : req_b[0 +: W];
                exp_q.push_back(ref_rsp(m_id, fl_ctrl[4:0], fl_a, fl_b));
                acc_cyc    = cyc;
                model_busy = 1'b1;
            end
            if (rsp_valid) begin
                if (!rsp_prev && exp_rsp_cyc >= 0) check("rsp_latency", cyc, exp_rsp_cyc);
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    check("rsp_fields", {rsp_id, rsp_result, rsp_error}, exp_q[0]);
                    if (rsp_ready) begin
                        pri        = ~exp_q[0].id;
                        prev_res   = last_res;
                        last_res   = rsp_result;
                        last_id    = rsp_id;
                        last_err   = rsp_error;
                        void'(exp_q.pop_front());
                        model_busy = 1'b0;
                    end
                end
            end
            rsp_prev = rsp_valid;
        end
    end

    // Behavioural ALU: answers each start pulse after 1..4 cycles.
    initial begin
        alu_valid = 1'b0; alu_error = 1'b0; alu_result = '0;
        forever begin
            @(negedge clk);
            if (!rst && alu_start) begin
                a_lat = $urandom_range(1, 4);
                check("alu_ctrl", {alu_fp, alu_rs2_signed, alu_rs1_signed, alu_op}, fl_ctrl);
                check("alu_a", alu_a, fl_a);
                check("alu_b", alu_b, fl_b);
                if (!busy_test) check("start_latency", cyc, acc_cyc + 1);
                a_op = alu_op; a_a = alu_a; a_b = alu_b;
                if (a_op == 5'd31) begin
`ifdef ALU_SCHED_TIMEOUT_EN
                    exp_rsp_cyc = cyc + 1 + TMO;
`else
                    exp_rsp_cyc = -1;
`endif
                end else begin
                    exp_rsp_cyc = cyc + 1 + a_lat;
                end
                @(posedge clk); #1;
                check("start_pulse_width", alu_start, 1'b0);
                if (a_op != 5'd31) begin
                    repeat (a_lat - 1) begin @(posedge clk); #1; end
                    case (a_op)
                        5'd6:  begin alu_valid = 1'b1; alu_result = a_a + a_b; end
                        5'd7:  begin alu_valid = 1'b1; alu_result = a_a - a_b; end
                        5'd10: begin alu_valid = 1'b1; alu_error = 1'b1; alu_result = a_a ^ a_b; end
                        5'd11: begin alu_error = 1'b1; alu_result = $urandom; end
                        default: begin alu_valid = 1'b1; alu_result = a_a ^ a_b; end
                    endcase
                    @(posedge clk); #1;
                    alu_valid = 1'b0; alu_error = 1'b0;
                end
            end
        end
    end

    // Random consumer back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rsp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int i, input logic [7:0] ctrl,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        req_ctrl[8*i +: 8] = ctrl;
        req_a[W*i +: W]    = a;
        req_b[W*i +: W]    = b;
        req_valid[i]       = 1'b1;
        do begin @(negedge clk); n++; end while (!req_ready[i] && n < 3000);
        if (!req_ready[i]) check("accept_timeout", req_ready[i], 1'b1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((model_busy || exp_q.size() != 0) && n < 5000) begin
            @(negedge clk); n++;
        end
        check("idle_timeout", model_busy, 1'b0);
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] rand_ctrl();
        logic [4:0] ops [5] = '{5'd3, 5'd6, 5'd7, 5'd10, 5'd11};
        return {3'($urandom_range(0, 7)), ops[$urandom_range(0, 4)]};
    endfunction

    initial begin
        int n;
        int r;
        rst = 1'b1; req_valid = '0; req_ctrl = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1; alu_busy = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("reset_outputs", |{req_ready, rsp_valid, rsp_id, rsp_result, rsp_error, alu_start,
                                 alu_op, alu_fp, alu_rs1_signed, alu_rs2_signed, alu_a, alu_b}, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: single add from requester 0
        send(0, 8'h06, 32'hA3B52F1D, 32'h7D3E9A0B);
        wait_idle();
        check("t1_result", last_res, 32'h20F3C928);
        check("t1_id", last_id, 1'b0);

        // Requester 1 once so that requester 0 has priority again
        send(1, 8'h03, 32'h0000FFFF, 32'h12345678);
        wait_idle();

        // T2: both requesters valid from the same cycle
        fork
            send(0, 8'h06, 32'hA3B52F1D, 32'h7D3E9A0B);
            send(1, 8'h07, 32'hA3B52F1D, 32'h7D3E9A0B);
        join
        wait_idle();
        check("t2_first_result", prev_res, 32'h20F3C928);
        check("t2_second_result", last_res, 32'h26769512);
        check("t2_second_id", last_id, 1'b1);

        // T3: consumer stalls for 20 cycles with both requesters waiting
        rsp_ready = 1'b0;
        send(0, 8'h83, 32'hCAFEF00D, 32'h0F0F0F0F);
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check("t3_rsp_seen", rsp_valid, 1'b1);
        @(posedge clk); #1;
        fork
            send(0, 8'h46, 32'h11111111, 32'h22222222);
            send(1, 8'h27, 32'h99999999, 32'h11111111);
            begin
                repeat (20) begin
                    @(negedge clk);
                    check("t3_stall_ready", req_ready, 2'b00);
                    check("t3_stall_valid", rsp_valid, 1'b1);
                end
                @(posedge clk); #1;
                rsp_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("t3_next_grant", req_ready, 2'b10);
            end
        join
        wait_idle();

        // T4: error with valid, then error without valid
        send(1, 8'h0A, 32'h5A5A5A5A, 32'h0000FFFF);
        wait_idle();
        check("t4_error", last_err, 1'b1);
        check("t4_id", last_id, 1'b1);
        send(0, 8'h0B, 32'h12345678, 32'h87654321);
        wait_idle();
        check("t4b_result", last_res, 32'h0);
        check("t4b_error", last_err, 1'b1);

        // Busy ALU holds off the start pulse
        busy_test = 1'b1;
        alu_busy  = 1'b1;
        send(1, 8'h06, 32'h00000001, 32'h00000002);
        repeat (3) begin @(negedge clk); check("busy_no_start", alu_start, 1'b0); end
        @(posedge clk); #1;
        alu_busy = 1'b0;
        wait_idle();
        busy_test = 1'b0;
        check("busy_result", last_res, 32'h00000003);

        // Random traffic with random back-pressure
        rsp_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 2);
            if (r == 0) begin
                send(0, rand_ctrl(), $urandom, $urandom);
            end else if (r == 1) begin
                send(1, rand_ctrl(), $urandom, $urandom);
            end else begin
                fork
                    send(0, rand_ctrl(), $urandom, $urandom);
                    send(1, rand_ctrl(), $urandom, $urandom);
                join
            end
        end
        rsp_rand = 1'b0;
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        wait_idle();

        // T5/T6: ALU never answers
        send(1, 8'h1F, 32'hDEADBEEF, 32'h1);
`ifdef ALU_SCHED_TIMEOUT_EN
        wait_idle();
        check("t5_result", last_res, 32'h0);
        check("t5_error", last_err, 1'b1);
        send(0, 8'h1F, 32'hDEADBEEF, 32'h1);
`endif
        repeat (20) begin @(negedge clk); check("hang_no_rsp", rsp_valid, 1'b0); end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", |{req_ready, rsp_valid, rsp_id, rsp_result, rsp_error, alu_start,
                                       alu_op, alu_fp, alu_rs1_signed, alu_rs2_signed, alu_a, alu_b}, 1'b0);
        exp_q.delete();
        model_busy  = 1'b0;
        pri         = 1'b0;
        exp_rsp_cyc = -1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(0, 8'h06, 32'hA3B52F1D, 32'h7D3E9A0B);
        wait_idle();
        check("t6_result", last_res, 32'h20F3C928);
        check("t6_id", last_id, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1);
    end

endmodule
